spi_peripheral: RTL and testbench



---
 rtl/spi_peripheral.sv | 168 ++++++++++++++++
 tb/tb_spi_peripheral.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 target (CPOL=0, CPHA=0), fixed 8-bit frames.
// SCLK, CS_n and MOSI are oversampled in the i_clk domain.
// MOSI is deserialised into bytes. A buffered transmit byte is serialised onto MISO.
// Local logic sees a valid/ready byte interface.
// Build option: define SPI_PERIPH_LSB_FIRST_EN to shift both directions LSB first.
// MSB first is the default.
module spi_peripheral (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_cs_n,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_tx_underrun,
  output logic       o_busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0] hold_q;
  logic       hold_full;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic [7:0] rx_shift, rx_nxt;
  logic [2:0] bit_cnt;
  logic       load, shift_out, sample, wr_en;
  logic       tx_bit;

  // Pin synchronisers. Bit 0 is the newest sample.
  // Stage 2 of SCLK/CS exists only for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_s <= 3'b000;
      cs_s   <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sclk_s <= {sclk_s[1:0], i_sclk};
      cs_s   <= {cs_s[1:0], i_cs_n};
      mosi_s <= {mosi_s[0], i_mosi};
    end
  end

  assign sclk_rise =  sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] &  sclk_s[2];
  assign cs_fall   = ~cs_s[1]   &  cs_s[2];
  assign cs_rise   =  cs_s[1]   & ~cs_s[2];

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state plus per-cycle strobes.
  // An SCLK fall with the counter at 0 always follows a completed byte.
  // That fall is where the next byte gets loaded, including the trailing fall of the last byte.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_out = 1'b0;
    sample    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
        end else begin
          sample = sclk_rise;
          if (sclk_fall) begin
            if (bit_cnt == 3'd0) load      = 1'b1;
            else                 shift_out = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_en = i_tx_valid & ~hold_full;

  // Holding register.
  // A write landing on the same cycle as a load refills the register.
  // That load has already seen it empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q    <= 8'h00;
      hold_full <= 1'b0;
    end else if (wr_en) begin
      hold_q    <= i_tx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

`ifdef SPI_PERIPH_LSB_FIRST_EN
  assign tx_bit       = tx_shift[0];
  assign tx_shift_nxt = {1'b0, tx_shift[7:1]};
  assign rx_nxt       = {mosi_s[1], rx_shift[7:1]};
`else
  assign tx_bit       = tx_shift[7];
  assign tx_shift_nxt = {tx_shift[6:0], 1'b0};
  assign rx_nxt       = {rx_shift[6:0], mosi_s[1]};
`endif

  // Transmit shifter: load from holding (zeros plus underrun when empty), shift on SCLK fall
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_shift      <= 8'h00;
      o_tx_underrun <= 1'b0;
    end else begin
      o_tx_underrun <= 1'b0;
      if (load) begin
        if (hold_full) begin
          tx_shift <= hold_q;
        end else begin
          tx_shift      <= 8'h00;
          o_tx_underrun <= 1'b1;
        end
      end else if (shift_out) begin
        tx_shift <= tx_shift_nxt;
      end
    end
  end

  // Receive shifter and bit counter.
  // A partial byte is dropped whenever the target is deselected.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_shift   <= 8'h00;
      bit_cnt    <= 3'd0;
      o_rx_data  <= 8'h00;
      o_rx_valid <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      if (state == IDLE || cs_rise) begin
        bit_cnt <= 3'd0;
      end else if (sample) begin
        rx_shift <= rx_nxt;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          o_rx_data  <= rx_nxt;
          o_rx_valid <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = (state == ACTIVE);
  assign o_miso_oe  = o_busy;
  assign o_miso     = o_busy & tx_bit;
  assign o_tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral. It acts as a mode-0 controller at f_clk/8.
module tb_spi_peripheral;

  logic       clk, rst_n, sclk, cs_n, mosi;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data, rx_data;

  int         nvec = 0;
  int         nerr = 0;
  int         rxv_cnt = 0;
  int         urn_cnt = 0;
  logic [7:0] rx_hist [0:15];

  spi_peripheral dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_tx_underrun(tx_underrun), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_hist[rxv_cnt % 16] = rx_data;
      rxv_cnt++;
    end
    if (tx_underrun) urn_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wr_byte(input logic [7:0] d);
    @(negedge clk); tx_valid = 1'b1; tx_data = d;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk); cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Clock nbits out. wb holds wire order (first bit in [7]); mb holds MISO re-assembled as a byte.
  task automatic spi_bits(input logic [7:0] mo, input int nbits,
                          output logic [7:0] wb, output logic [7:0] mb);
    int idx;
    wb = 8'h00; mb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
`ifdef SPI_PERIPH_LSB_FIRST_EN
      idx = i;
`else
      idx = 7 - i;
`endif
      mosi = mo[idx];
      repeat (4) @(negedge clk);
      wb[7-i] = miso;
      mb[idx] = miso;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    nvec++; if (miso !== 1'b0)        begin nerr++; $display("FAIL rst_miso: got %b exp 0", miso); end
    nvec++; if (miso_oe !== 1'b0)     begin nerr++; $display("FAIL rst_miso_oe: got %b exp 0", miso_oe); end
    nvec++; if (tx_ready !== 1'b1)    begin nerr++; $display("FAIL rst_tx_ready: got %b exp 1", tx_ready); end
    nvec++; if (rx_data !== 8'h00)    begin nerr++; $display("FAIL rst_rx_data: got %h exp 00", rx_data); end
    nvec++; if (rx_valid !== 1'b0)    begin nerr++; $display("FAIL rst_rx_valid: got %b exp 0", rx_valid); end
    nvec++; if (tx_underrun !== 1'b0) begin nerr++; $display("FAIL rst_underrun: got %b exp 0", tx_underrun); end
    nvec++; if (busy !== 1'b0)        begin nerr++; $display("FAIL rst_busy: got %b exp 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [7:0] wb, mb;
    int r0;
    wr_byte(8'hA5);
    nvec++; if (tx_ready !== 1'b0) begin nerr++; $display("FAIL sf_ready_after_wr: got %b exp 0", tx_ready); end
    r0 = rxv_cnt;
    cs_low();
    nvec++; if (tx_ready !== 1'b1) begin nerr++; $display("FAIL sf_ready_after_load: got %b exp 1", tx_ready); end
    nvec++; if (busy !== 1'b1 || miso_oe !== 1'b1) begin nerr++; $display("FAIL sf_busy_oe: got %b%b exp 11", busy, miso_oe); end
    spi_bits(8'h3C, 8, wb, mb);
    nvec++; if (wb !== 8'b10100101) begin nerr++; $display("FAIL sf_miso_wire: got %b exp 10100101", wb); end
    nvec++; if (rxv_cnt - r0 !== 1) begin nerr++; $display("FAIL sf_rx_pulses: got %0d exp 1", rxv_cnt - r0); end
    nvec++; if (rx_data !== 8'h3C)  begin nerr++; $display("FAIL sf_rx_data: got %h exp 3c", rx_data); end
    cs_high();
    nvec++; if (miso_oe !== 1'b0)   begin nerr++; $display("FAIL sf_oe_idle: got %b exp 0", miso_oe); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wb, mb;
    int r0, u0;
    logic [7:0] txv [0:2];
    logic [7:0] rxv [0:2];
    txv[0] = 8'h22; txv[1] = 8'h33; txv[2] = 8'h44;  // next-byte refills; 0x44 covers the trailing fall
    rxv[0] = 8'hDE; rxv[1] = 8'hAD; rxv[2] = 8'hBE;
    r0 = rxv_cnt; u0 = urn_cnt;
    wr_byte(8'h11);
    cs_low();
    for (int k = 0; k < 3; k++) begin
      wr_byte(txv[k]);
      spi_bits(rxv[k], 8, wb, mb);
      nvec++; if (mb !== 8'h11 * (k + 1)) begin nerr++; $display("FAIL b2b_miso%0d: got %h exp %h", k, mb, 8'h11 * (k + 1)); end
      nvec++; if (rx_hist[(r0 + k) % 16] !== rxv[k]) begin nerr++; $display("FAIL b2b_rx%0d: got %h exp %h", k, rx_hist[(r0 + k) % 16], rxv[k]); end
    end
    cs_high();
    nvec++; if (rxv_cnt - r0 !== 3) begin nerr++; $display("FAIL b2b_rx_pulses: got %0d exp 3", rxv_cnt - r0); end
    nvec++; if (urn_cnt - u0 !== 0) begin nerr++; $display("FAIL b2b_underruns: got %0d exp 0", urn_cnt - u0); end
  endtask

  task automatic test_underrun();
    logic [7:0] wb, mb;
    int u0;
    // A write coincides with the CS-fall load: that load underruns, and the written byte lands in the next byte slot
    @(negedge clk); cs_n = 1'b0;
    @(negedge clk);
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h5A;
    @(negedge clk); tx_valid = 1'b0;
    nvec++; if (tx_underrun !== 1'b1) begin nerr++; $display("FAIL ur_coinc_pulse: got %b exp 1", tx_underrun); end
    nvec++; if (tx_ready !== 1'b0)    begin nerr++; $display("FAIL ur_coinc_held: got %b exp 0", tx_ready); end
    repeat (2) @(negedge clk);
    spi_bits(8'h12, 8, wb, mb);
    nvec++; if (mb !== 8'h00) begin nerr++; $display("FAIL ur_coinc_b0: got %h exp 00", mb); end
    spi_bits(8'h34, 8, wb, mb);
    nvec++; if (mb !== 8'h5A) begin nerr++; $display("FAIL ur_coinc_b1: got %h exp 5a", mb); end
    cs_high();
    // Empty holding at CS fall: exactly one pulse before any SCLK activity
    u0 = urn_cnt;
    cs_low();
    nvec++; if (urn_cnt - u0 !== 1) begin nerr++; $display("FAIL ur_empty_pulses: got %0d exp 1", urn_cnt - u0); end
    spi_bits(8'h81, 8, wb, mb);
    nvec++; if (mb !== 8'h00) begin nerr++; $display("FAIL ur_empty_miso: got %h exp 00", mb); end
    cs_high();
  endtask

  task automatic test_cs_abort();
    logic [7:0] wb, mb;
    int r0;
    r0 = rxv_cnt;
    cs_low();
    wr_byte(8'h77);
    spi_bits(8'hFF, 5, wb, mb);
    cs_high();
    nvec++; if (rxv_cnt - r0 !== 0) begin nerr++; $display("FAIL ab_no_rx: got %0d exp 0", rxv_cnt - r0); end
    nvec++; if (miso_oe !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL ab_idle: got %b%b exp 00", miso_oe, busy); end
    nvec++; if (tx_ready !== 1'b0)  begin nerr++; $display("FAIL ab_hold_kept: got %b exp 0", tx_ready); end
    cs_low();
    spi_bits(8'h96, 8, wb, mb);
    cs_high();
    nvec++; if (mb !== 8'h77)       begin nerr++; $display("FAIL ab_next_miso: got %h exp 77", mb); end
    nvec++; if (rx_data !== 8'h96)  begin nerr++; $display("FAIL ab_next_rx: got %h exp 96", rx_data); end
    nvec++; if (rxv_cnt - r0 !== 1) begin nerr++; $display("FAIL ab_next_pulses: got %0d exp 1", rxv_cnt - r0); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] wb, mb;
    wr_byte(8'hC3);
    cs_low();
    spi_bits(8'hAA, 4, wb, mb);
    rst_n = 1'b0;
    #1;
    nvec++; if (miso_oe !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rm_idle: got %b%b exp 00", miso_oe, busy); end
    nvec++; if (tx_ready !== 1'b1)  begin nerr++; $display("FAIL rm_ready: got %b exp 1", tx_ready); end
    nvec++; if (rx_data !== 8'h00)  begin nerr++; $display("FAIL rm_rx_data: got %h exp 00", rx_data); end
    nvec++; if (miso !== 1'b0)      begin nerr++; $display("FAIL rm_miso: got %b exp 0", miso); end
    sclk = 1'b0; cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wr_byte(8'hE7);
    cs_low();
    spi_bits(8'h5B, 8, wb, mb);
    cs_high();
    nvec++; if (mb !== 8'hE7)      begin nerr++; $display("FAIL rm_next_miso: got %h exp e7", mb); end
    nvec++; if (rx_data !== 8'h5B) begin nerr++; $display("FAIL rm_next_rx: got %h exp 5b", rx_data); end
  endtask

`ifdef SPI_PERIPH_LSB_FIRST_EN
  task automatic test_lsb_first();
    logic [7:0] wb, mb;
    wr_byte(8'h01);
    cs_low();
    spi_bits(8'h01, 8, wb, mb);
    cs_high();
    nvec++; if (wb !== 8'b10000000) begin nerr++; $display("FAIL lsb_miso_wire: got %b exp 10000000", wb); end
    nvec++; if (rx_data !== 8'h01)  begin nerr++; $display("FAIL lsb_rx: got %h exp 01", rx_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_cs_abort();
    test_reset_midframe();
`ifdef SPI_PERIPH_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
